multi_phase_timer: RTL and testbench

//  N_CH independent down-counting phase timers sharing one tick strobe (enable).

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_channel.sv | 64 ++++++
 rtl/multi_phase_timer.sv | 68 ++++++
 tb/tb_multi_phase_timer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants for the multi-phase timer (mode and channel state encodings)
package timer_pkg;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_WIDTH = 8;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counting phase timer channel, IDLE <-> RUN
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] tp_val,
  input  logic             start_t,
  input  logic             stop,
  input  logic             mode,
  output logic             busy,
  output logic             expired,
  output logic [WIDTH-1:0] count
);

  logic [0:0]       state;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;

  // Priority stop > start_t > tick; count never rests at zero while RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
      count    <= '0;
      expired  <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        count <= '0;
      end else if (start_t) begin
        period_q <= tp_val;
        mode_q   <= mode;
        count    <= tp_val;
        if (tp_val == '0) begin
          state   <= ST_IDLE;
          expired <= 1'b1;
        end else begin
          state <= ST_RUN;
        end
      end else if (tick && state == ST_RUN) begin
        if (count > WIDTH'(1)) begin
          count <= count - WIDTH'(1);
        end else begin
          expired <= 1'b1;
          if (mode_q == MODE_RELOAD) begin
            count <= period_q;
          end else begin
            count <= '0;
            state <= ST_IDLE;
          end
        end
      end
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: rtl/multi_phase_timer.sv
// rtl/multi_phase_timer.sv - N_CH phase timers on a shared tick; optional prescaler via TIMER_PRESCALE_EN
module multi_phase_timer
  import timer_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [N_CH*WIDTH-1:0] tp_val,
  input  logic [N_CH-1:0]       start_t,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       mode,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       expired,
  output logic [N_CH*WIDTH-1:0] count
);

  logic tick;

`ifdef TIMER_PRESCALE_EN
  generate
    if (PRESCALE >= 2) begin : g_pre
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre;

      // Free-running: start_t/stop never realign the prescale phase.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pre <= '0;
        end else if (enable) begin
          if (pre == PRE_LAST) pre <= '0;
          else                 pre <= pre + PW'(1);
        end
      end

      assign tick = enable && (pre == PRE_LAST);
    end else begin : g_nopre
      assign tick = enable;
    end
  endgenerate
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE > 0);
  assign tick = enable;
`endif

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      timer_channel #(.WIDTH(WIDTH)) u_ch (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .tp_val  (tp_val[i*WIDTH +: WIDTH]),
        .start_t (start_t[i]),
        .stop    (stop[i]),
        .mode    (mode[i]),
        .busy    (busy[i]),
        .expired (expired[i]),
        .count   (count[i*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_phase_timer.sv
// tb/tb_multi_phase_timer.sv - directed self-checking bench for multi_phase_timer
module tb_multi_phase_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] tp_val;
  logic [3:0]  start_t;
  logic [3:0]  stop;
  logic [3:0]  mode;
  logic [3:0]  busy;
  logic [3:0]  expired;
  logic [31:0] count;

  int errors = 0;
  int checks = 0;
  int exp_seen [4] = '{0, 0, 0, 0};

  multi_phase_timer #(.N_CH(4), .WIDTH(8), .PRESCALE(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tp_val  (tp_val),
    .start_t (start_t),
    .stop    (stop),
    .mode    (mode),
    .busy    (busy),
    .expired (expired),
    .count   (count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (expired[i] === 1'b1) exp_seen[i]++;
  end

  task automatic clk_cycle(input logic en);
    enable = en;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  // Enable arrives every third clock.
  task automatic tick3();
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    clk_cycle(1'b1);
  endtask

  task automatic start_ch(input int ch, input logic [7:0] v, input logic m, input logic en);
    tp_val[ch*8 +: 8] = v;
    mode[ch]          = m;
    start_t[ch]       = 1'b1;
    clk_cycle(en);
    start_t[ch]       = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic test_reset();
    int e0;
    reset_n = 1'b0;
    repeat (2) clk_cycle(1'b0);
    chk("reset count", int'(count), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset expired", int'(expired), 0);
    reset_n = 1'b1;
    clk_cycle(1'b0);
    start_ch(0, 8'd7, 1'b0, 1'b0);
    tick3();
    tick3();
    chk("pre-reset ch0 count", int'(count[7:0]), 5);
    e0 = exp_seen[0];
    #2 reset_n = 1'b0;
    #1;
    chk("async reset count", int'(count), 0);
    chk("async reset busy", int'(busy), 0);
    chk("async reset expired", int'(expired), 0);
    clk_cycle(1'b1);
    clk_cycle(1'b0);
    chk("async reset no pulse", exp_seen[0] - e0, 0);
    reset_n = 1'b1;
    clk_cycle(1'b0);
  endtask

  task automatic test_oneshot();
    int e0;
    e0 = exp_seen[0];
    start_ch(0, 8'd3, 1'b0, 1'b0);
    chk("oneshot start count", int'(count[7:0]), 3);
    chk("oneshot start busy", int'(busy[0]), 1);
    tick3();
    chk("oneshot count after t1", int'(count[7:0]), 2);
    tick3();
    chk("oneshot count after t2", int'(count[7:0]), 1);
    chk("oneshot no early pulse", int'(expired[0]), 0);
    tick3();
    chk("oneshot count after t3", int'(count[7:0]), 0);
    chk("oneshot expired", int'(expired[0]), 1);
    chk("oneshot busy falls", int'(busy[0]), 0);
    clk_cycle(1'b0);
    chk("oneshot expired clears", int'(expired[0]), 0);
    chk("oneshot one pulse", exp_seen[0] - e0, 1);
    chk("oneshot ch1 untouched", int'(count[15:8]), 0);
    tick3();
    chk("oneshot idle tick", int'(count[7:0]), 0);
  endtask

  task automatic test_reload();
    int e1;
    e1 = exp_seen[1];
    start_ch(1, 8'd2, 1'b1, 1'b0);
    tp_val[15:8] = 8'd9;
    mode[1]      = 1'b0;
    tick3();
    chk("reload count 1", int'(count[15:8]), 1);
    tick3();
    chk("reload expired 1", int'(expired[1]), 1);
    chk("reload reloads", int'(count[15:8]), 2);
    chk("reload busy", int'(busy[1]), 1);
    tick3();
    chk("reload count 1b", int'(count[15:8]), 1);
    tick3();
    chk("reload expired 2", int'(expired[1]), 1);
    chk("reload reloads 2", int'(count[15:8]), 2);
    tick3();
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    stop[1] = 1'b1;
    clk_cycle(1'b1);
    stop[1] = 1'b0;
    chk("stop busy", int'(busy[1]), 0);
    chk("stop count", int'(count[15:8]), 0);
    chk("stop expired", int'(expired[1]), 0);
    clk_cycle(1'b0);
    chk("reload pulse total", exp_seen[1] - e1, 2);
  endtask

  task automatic test_zero_period();
    int e2;
    e2 = exp_seen[2];
    start_ch(2, 8'd0, 1'b0, 1'b0);
    chk("zero busy", int'(busy[2]), 0);
    chk("zero expired", int'(expired[2]), 1);
    chk("zero count", int'(count[23:16]), 0);
    clk_cycle(1'b0);
    chk("zero expired clears", int'(expired[2]), 0);
    chk("zero busy stays", int'(busy[2]), 0);
    chk("zero one pulse", exp_seen[2] - e2, 1);
    start_ch(2, 8'd5, 1'b0, 1'b1);
    chk("start+tick count", int'(count[23:16]), 5);
    chk("start+tick busy", int'(busy[2]), 1);
    stop[2] = 1'b1;
    clk_cycle(1'b0);
    stop[2] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int e3;
    start_ch(3, 8'd2, 1'b0, 1'b0);
    tick3();
    chk("restart pre count", int'(count[31:24]), 1);
    e3 = exp_seen[3];
    start_ch(3, 8'd4, 1'b0, 1'b1);
    chk("restart count", int'(count[31:24]), 4);
    chk("restart busy", int'(busy[3]), 1);
    chk("restart no expired", int'(expired[3]), 0);
    clk_cycle(1'b0);
    chk("restart no pulse", exp_seen[3] - e3, 0);
    stop[3] = 1'b1;
    start_ch(3, 8'd6, 1'b0, 1'b0);
    stop[3] = 1'b0;
    chk("stop+start busy", int'(busy[3]), 0);
    chk("stop+start count", int'(count[31:24]), 0);
    chk("stop+start expired", int'(expired[3]), 0);
  endtask

`ifdef TIMER_PRESCALE_EN
  task automatic test_prescale();
    reset_n = 1'b0;
    clk_cycle(1'b0);
    reset_n = 1'b1;
    clk_cycle(1'b0);
    start_ch(0, 8'd2, 1'b0, 1'b0);
    repeat (5) tick3();
    chk("prescale no early expire", int'(expired[0]), 0);
    chk("prescale count", int'(count[7:0]), 1);
    tick3();
    chk("prescale expired", int'(expired[0]), 1);
    chk("prescale others idle", int'(busy[3:1]), 0);
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    tp_val  = '0;
    start_t = '0;
    stop    = '0;
    mode    = '0;
    test_reset();
    test_oneshot();
    test_reload();
    test_zero_period();
    test_back_to_back();
`ifdef TIMER_PRESCALE_EN
    test_prescale();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
